// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default bus timing
// at 50 MHz and the common keyboard command/response bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INHIBIT    = 3'd1,
        ST_RTS        = 3'd2,
        ST_WAIT_FIRST = 3'd3,
        ST_SEND       = 3'd4,
        ST_WAIT_ACK   = 3'd5,
        ST_WAIT_IDLE  = 3'd6
    } ps2_tx_state_t;

    localparam int DEF_INHIBIT_CYCLES        = 6000;
    localparam int DEF_RTS_CYCLES            = 50;
    localparam int DEF_START_TIMEOUT_CYCLES  = 750000;
    localparam int DEF_PACKET_TIMEOUT_CYCLES = 100000;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host controller and the PS/2 transmitter.
interface ps2_host_tx_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-drain PS/2 line plus falling-edge
// detect; idles high so a released bus never looks like an edge.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_sync,
    output logic fall
);
    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= line_in;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign line_sync = sync_reg;
    assign fall      = prev_reg & ~sync_reg;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts
// one byte out on device clock edges and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES        = DEF_INHIBIT_CYCLES,
    parameter int RTS_CYCLES            = DEF_RTS_CYCLES,
    parameter int START_TIMEOUT_CYCLES  = DEF_START_TIMEOUT_CYCLES,
    parameter int PACKET_TIMEOUT_CYCLES = DEF_PACKET_TIMEOUT_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       nReset,
    input  logic       Cmd_Valid,
    input  logic [7:0] Cmd_Data,
    output logic       Cmd_Ready,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_Error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);
    localparam int CNT_MAX = max_int(max_int(INHIBIT_CYCLES, RTS_CYCLES),
                                     max_int(START_TIMEOUT_CYCLES, PACKET_TIMEOUT_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PACKET_LAST  = CNT_W'(PACKET_TIMEOUT_CYCLES - 1);

    ps2_tx_state_t    state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       data_reg, data_next;
    logic             parity_reg, parity_next;
    logic             cur_bit_reg, cur_bit_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall_unused;
    logic clk_low, dat_low;

    ps2_line_sync u_clk_sync (
        .clk       (CLOCK_50),
        .rst_n     (nReset),
        .line_in   (PS2_CLK),
        .line_sync (clk_sync),
        .fall      (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clk       (CLOCK_50),
        .rst_n     (nReset),
        .line_in   (PS2_DAT),
        .line_sync (dat_sync),
        .fall      (dat_fall_unused)
    );

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            data_reg    <= '0;
            parity_reg  <= 1'b0;
            cur_bit_reg <= 1'b1;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            data_reg    <= data_next;
            parity_reg  <= parity_next;
            cur_bit_reg <= cur_bit_next;
            done_reg    <= done_next;
            error_reg   <= error_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        data_next    = data_reg;
        parity_next  = parity_reg;
        cur_bit_next = cur_bit_reg;
        done_next    = 1'b0;
        error_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (Cmd_Valid) begin
                    data_next   = Cmd_Data;
                    parity_next = odd_parity(Cmd_Data);
                    cnt_next    = '0;
                    state_next  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (cnt_reg == INHIBIT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_RTS;
                end
            end
            ST_RTS: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (cnt_reg == RTS_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_WAIT_FIRST;
                end
            end
            ST_WAIT_FIRST: begin
                cnt_next = cnt_reg + CNT_ONE;
                // An edge arriving in the expiry cycle still starts the frame.
                if (clk_fall) begin
                    cur_bit_next = data_reg[0];
                    bit_idx_next = 4'd1;
                    cnt_next     = '0;
                    state_next   = ST_SEND;
                end else if (cnt_reg >= START_LAST) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_SEND: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (clk_fall) begin
                    bit_idx_next = bit_idx_reg + 4'd1;
                    if (bit_idx_reg == 4'd9) begin
                        state_next = ST_WAIT_ACK;
                    end else if (bit_idx_reg == 4'd8) begin
                        cur_bit_next = parity_reg;
                    end else begin
                        cur_bit_next = data_reg[bit_idx_reg[2:0]];
                    end
                end else if (cnt_reg >= PACKET_LAST) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (clk_fall) begin
                    if (dat_sync) begin
                        error_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT_IDLE;
                    end
                end else if (cnt_reg >= PACKET_LAST) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Line drives decode straight from state so reset releases the bus at once.
    assign clk_low = (state_reg == ST_INHIBIT) || (state_reg == ST_RTS);
    assign dat_low = (state_reg == ST_RTS) || (state_reg == ST_WAIT_FIRST) ||
                     ((state_reg == ST_SEND) && !cur_bit_reg);

    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    assign Cmd_Ready = (state_reg == ST_IDLE);
    assign Tx_Busy   = ~Cmd_Ready;
    assign Tx_Done   = done_reg;
    assign Tx_Error  = error_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of
// the host and a scoreboard holds the frame and outcome each command should give.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int TB_START_TO = 3000;
    localparam int HALF        = 20;

    typedef struct {
        logic [10:0] frame;
        int          done;
        int          err;
    } exp_t;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    ps2_host_tx_if cmd_if ();

    wire  ps2_clk;
    wire  ps2_dat;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .START_TIMEOUT_CYCLES (TB_START_TO)
    ) dut (
        .CLOCK_50  (clk),
        .nReset    (nreset),
        .Cmd_Valid (cmd_if.cmd_valid),
        .Cmd_Data  (cmd_if.cmd_data),
        .Cmd_Ready (cmd_if.cmd_ready),
        .Tx_Busy   (cmd_if.tx_busy),
        .Tx_Done   (cmd_if.tx_done),
        .Tx_Error  (cmd_if.tx_error),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    exp_t sb[$];

    always @(negedge clk) begin
        if (cmd_if.tx_done === 1'b1)  done_cnt++;
        if (cmd_if.tx_error === 1'b1) err_cnt++;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: observed no finish, required finish within 150000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        while (cmd_if.cmd_ready !== 1'b1 && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("ready before send", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_data  = b;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        check("busy after accept", 32'(cmd_if.tx_busy), 32'd1);
    endtask

    // Returns on the first negedge after the host releases the clock.
    task automatic measure_request(input string tag);
        int inh = 0;
        int rts = 0;
        @(negedge clk);
        while (ps2_clk === 1'b0 && ps2_dat === 1'b1 && inh < 20000) begin
            inh++;
            @(negedge clk);
        end
        while (ps2_clk === 1'b0 && ps2_dat === 1'b0 && rts < 1000) begin
            rts++;
            @(negedge clk);
        end
        check({tag, " inhibit cycles"}, 32'(inh), 32'd6000);
        check({tag, " rts cycles"}, 32'(rts), 32'd50);
        check({tag, " clock released"}, 32'(ps2_clk), 32'd1);
    endtask

    // Device side: bits[0] is the start bit, bits[k] is sampled on rising edge k.
    task automatic dev_frame(input int npulses, input logic ack, output logic [10:0] bits);
        bits = '1;
        repeat (30) @(negedge clk);
        bits[0] = ps2_dat;
        for (int k = 1; k <= npulses && k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            @(negedge clk);
            bits[k] = ps2_dat;
            repeat (HALF - 1) @(negedge clk);
        end
        if (npulses == 11) begin
            dev_dat_low = ack;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_dat_low = 1'b0;
            repeat (20) @(negedge clk);
        end
    endtask

    task automatic finish_transfer(input string tag, input logic ack);
        logic [10:0] bits;
        int   d0;
        int   e0;
        exp_t e;
        measure_request(tag);
        d0 = done_cnt;
        e0 = err_cnt;
        dev_frame(11, ack, bits);
        check({tag, " scoreboard entry"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " frame"}, 32'(bits), 32'(e.frame));
            check({tag, " done pulses"}, 32'(done_cnt - d0), 32'(e.done));
            check({tag, " error pulses"}, 32'(err_cnt - e0), 32'(e.err));
        end
        check({tag, " ready after"}, 32'(cmd_if.cmd_ready), 32'd1);
        check({tag, " busy after"}, 32'(cmd_if.tx_busy), 32'd0);
    endtask

    task automatic run_transfer(input logic [7:0] b, input logic ack);
        sb.push_back('{frame: exp_frame(b), done: ack ? 1 : 0, err: ack ? 0 : 1});
        send_cmd(b);
        finish_transfer($sformatf("tx %02h", b), ack);
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  b;
        int          k;
        int          d0;
        int          e0;

        nreset           = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("reset busy", 32'(cmd_if.tx_busy), 32'd0);
        check("reset done", 32'(cmd_if.tx_done), 32'd0);
        check("reset error", 32'(cmd_if.tx_error), 32'd0);
        check("reset clk line", 32'(ps2_clk), 32'd1);
        check("reset dat line", 32'(ps2_dat), 32'd1);
        nreset = 1'b1;
        repeat (5) @(negedge clk);

        run_transfer(CMD_SET_LEDS, 1'b1);
        run_transfer(8'h01, 1'b1);
        run_transfer(CMD_RESET, 1'b1);
        run_transfer(8'h5A, 1'b0);

        // Device never clocks after the request-to-send.
        b = 8'hA5;
        send_cmd(b);
        measure_request("timeout");
        d0 = done_cnt;
        e0 = err_cnt;
        k  = 0;
        while (cmd_if.tx_error !== 1'b1 && k < TB_START_TO + 200) begin
            @(negedge clk);
            k++;
        end
        check("start timeout cycles", 32'(k), 32'(TB_START_TO));
        check("timeout clk line", 32'(ps2_clk), 32'd1);
        check("timeout dat line", 32'(ps2_dat), 32'd1);
        repeat (5) @(negedge clk);
        check("timeout error pulses", 32'(err_cnt - e0), 32'd1);
        check("timeout done pulses", 32'(done_cnt - d0), 32'd0);

        // Reset lands after edge 4 while a new command is offered.
        b = CMD_ENABLE;
        send_cmd(b);
        measure_request("reset run");
        dev_frame(4, 1'b0, bits);
        check("reset run partial frame", 32'(bits[4:0]), 32'({b[3:0], 1'b0}));
        check("reset run bit3 driven", 32'(ps2_dat), 32'd0);
        d0 = done_cnt;
        e0 = err_cnt;
        cmd_if.cmd_data  = b;
        cmd_if.cmd_valid = 1'b1;
        @(negedge clk);
        check("valid ignored while busy", 32'(cmd_if.tx_busy), 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("async reset dat line", 32'(ps2_dat), 32'd1);
        check("async reset clk line", 32'(ps2_clk), 32'd1);
        check("async reset ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("async reset busy", 32'(cmd_if.tx_busy), 32'd0);
        check("async reset done", 32'(cmd_if.tx_done), 32'd0);
        check("async reset error", 32'(cmd_if.tx_error), 32'd0);
        repeat (5) @(negedge clk);
        check("no accept in reset", 32'(cmd_if.tx_busy), 32'd0);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        check("accept after reset", 32'(cmd_if.tx_busy), 32'd1);
        cmd_if.cmd_valid = 1'b0;
        check("reset no done", 32'(done_cnt - d0), 32'd0);
        check("reset no error", 32'(err_cnt - e0), 32'd0);
        sb.push_back('{frame: exp_frame(b), done: 1, err: 0});
        finish_transfer("tx f4 after reset", 1'b1);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
